// File: rtl/des_search_pkg.sv
// Shared types and helpers for the multi-lane DES key-search engine.
package des_search_pkg;

  localparam int unsigned KEY56_W = 56;
  localparam int unsigned BLOCK_W = 64;

  typedef enum logic [1:0] {StIdle, StSearch, StDrain, StDone} state_e;

  // Each 7-bit key group becomes a byte with odd parity in bit 0.
  function automatic logic [BLOCK_W-1:0] expand_parity(input logic [KEY56_W-1:0] k);
    logic [BLOCK_W-1:0] out;
    out = '0;
    for (int j = 0; j < 8; j++) begin
      out[8*j+1 +: 7] = k[7*j +: 7];
      out[8*j]        = ~^k[7*j +: 7];
    end
    return out;
  endfunction

endpackage

// File: rtl/des_core.sv
// Combinational single-block DES; encrypt=0 runs the subkeys in reverse.
module des_core (
  input  logic [63:0] key,
  input  logic [63:0] din,
  input  logic        encrypt,
  output logic [63:0] dout
);

  // Tables use the standard numbering where position 1 is the MSB.
  localparam int IP [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                             62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                             57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                             61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                             38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                             36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                             34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int E [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                            12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23,
                            24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                            2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                              10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                              14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2 [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                              23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  // Entry {row, col} sits at nibble index row*16+col counted from the MSB.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  logic [55:0] cd;
  logic [27:0] c, d;
  logic [47:0] sk [16];
  logic [63:0] ipv, pre;
  logic [31:0] l, r, f, sout, tmp;
  logic [47:0] er, x, kr;
  logic [5:0]  b, sidx;

  always_comb begin
    cd = '0; c = '0; d = '0; ipv = '0; pre = '0; l = '0; r = '0; f = '0; sout = '0; tmp = '0;
    er = '0; x = '0; kr = '0; b = '0; sidx = '0; dout = '0;
    for (int k = 0; k < 16; k++) sk[k] = '0;

    for (int i = 0; i < 56; i++) cd[55-i] = key[6'(64 - PC1[i])];
    c = cd[55:28];
    d = cd[27:0];
    for (int rd = 0; rd < 16; rd++) begin
      if (SHIFTS[rd] == 2) begin
        c = {c[25:0], c[27:26]};
        d = {d[25:0], d[27:26]};
      end else begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) sk[rd][47-i] = cd[6'(56 - PC2[i])];
    end

    for (int i = 0; i < 64; i++) ipv[63-i] = din[6'(64 - IP[i])];
    l = ipv[63:32];
    r = ipv[31:0];
    for (int rd = 0; rd < 16; rd++) begin
      kr = encrypt ? sk[rd] : sk[15-rd];
      for (int i = 0; i < 48; i++) er[47-i] = r[5'(32 - E[i])];
      x = er ^ kr;
      for (int s = 0; s < 8; s++) begin
        b    = x[47-6*s -: 6];
        sidx = {b[5], b[0], b[4:1]};
        sout[31-4*s -: 4] = SBOX[s][8'(255 - 4 * sidx) -: 4];
      end
      for (int i = 0; i < 32; i++) f[31-i] = sout[5'(32 - P[i])];
      tmp = l ^ f;
      l   = r;
      r   = tmp;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) dout[63-i] = pre[6'(64 - FP[i])];
  end

endmodule

// File: rtl/key_parity_expand.sv
// Combinational 56-bit to 64-bit DES key expansion with odd parity bytes.
module key_parity_expand
  import des_search_pkg::*;
(
  input  logic [KEY56_W-1:0] k,
  output logic [BLOCK_W-1:0] key
);

  assign key = expand_parity(k);

endmodule

// File: rtl/des_key_search.sv
// Multi-lane brute-force DES key search: sweeps [key_lo, key_hi] and reports the
// lowest key whose DES result matches the known pair.
module des_key_search
  import des_search_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned PIPE  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [BLOCK_W-1:0]  plaintext,
  input  logic [BLOCK_W-1:0]  ciphertext,
  input  logic [KEY56_W-1:0]  key_lo,
  input  logic [KEY56_W-1:0]  key_hi,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [BLOCK_W-1:0]  key,
  output logic [KEY56_W-1:0]  count
);

  localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;

  state_e               state_q, state_d;
  logic                 mode_q, mode_d, done_q, done_d, found_q, found_d;
  logic [BLOCK_W-1:0]   pt_q, pt_d, ct_q, ct_d, key_q, key_d;
  logic [KEY56_W-1:0]   hi_q, hi_d, count_q, count_d;

  logic [BLOCK_W-1:0]   des_in, target;
  logic [KEY56_W-1:0]   lane_k     [LANES];
  logic [BLOCK_W-1:0]   lane_key64 [LANES];
  logic [BLOCK_W-1:0]   lane_res   [LANES];
  logic [LANES-1:0]     lane_valid, issue_valid;
  logic [BLOCK_W-1:0]   st_res     [LANES];
  logic [LANES-1:0]     st_valid;
  logic [KEY56_W-1:0]   st_base;
  logic                 hit, last_batch;
  logic [IdxW-1:0]      hit_idx;
  logic [KEY56_W:0]     batch_end;

  assign des_in = mode_q ? pt_q : ct_q;
  assign target = mode_q ? ct_q : pt_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_k[i] = count_q + KEY56_W'(i);
    // 57-bit compare so a batch straddling 2^56-1 masks lanes instead of wrapping.
    assign lane_valid[i] = ({1'b0, count_q} + (KEY56_W+1)'(i)) <= {1'b0, hi_q};
    key_parity_expand u_expand (.k(lane_k[i]), .key(lane_key64[i]));
    des_core u_des (.key(lane_key64[i]), .din(des_in), .encrypt(mode_q), .dout(lane_res[i]));
  end

  assign issue_valid = (state_q == StSearch) ? lane_valid : '0;
  assign batch_end   = {1'b0, count_q} + (KEY56_W+1)'(LANES);
  assign last_batch  = batch_end > {1'b0, hi_q};

  if (PIPE != 0) begin : g_pipe
    always_ff @(posedge clk) begin
      if (reset) begin
        st_valid <= '0;
        st_base  <= '0;
        for (int i = 0; i < LANES; i++) st_res[i] <= '0;
      end else begin
        st_valid <= issue_valid;
        st_base  <= count_q;
        for (int i = 0; i < LANES; i++) st_res[i] <= lane_res[i];
      end
    end
  end else begin : g_nopipe
    assign st_valid = issue_valid;
    assign st_base  = count_q;
    assign st_res   = lane_res;
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (st_valid[i] && (st_res[i] == target)) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pt_d    = pt_q;
    ct_d    = ct_q;
    hi_d    = hi_q;
    count_d = count_q;
    done_d  = done_q;
    found_d = found_q;
    key_d   = key_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          mode_d  = mode;
          pt_d    = plaintext;
          ct_d    = ciphertext;
          hi_d    = key_hi;
          count_d = key_lo;
          found_d = 1'b0;
          key_d   = '0;
          if (key_lo > key_hi) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            done_d  = 1'b0;
            state_d = StSearch;
          end
        end
      end
      StSearch: begin
        if (hit) begin
          found_d = 1'b1;
          done_d  = 1'b1;
          key_d   = expand_parity(st_base + KEY56_W'(hit_idx));
          state_d = StDone;
        end else if (last_batch) begin
          // Without the stage register the last batch is already compared here.
          if (PIPE == 0) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StDrain;
          end
        end else begin
          count_d = count_q + KEY56_W'(LANES);
        end
      end
      StDrain: begin
        done_d  = 1'b1;
        state_d = StDone;
        if (hit) begin
          found_d = 1'b1;
          key_d   = expand_parity(st_base + KEY56_W'(hit_idx));
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      pt_q    <= '0;
      ct_q    <= '0;
      hi_q    <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
      hi_q    <= hi_d;
      count_q <= count_d;
      done_q  <= done_d;
      found_q <= found_d;
      key_q   <= key_d;
    end
  end

  assign busy  = (state_q == StSearch) || (state_q == StDrain);
  assign done  = done_q;
  assign found = found_q;
  assign key   = key_q;
  assign count = count_q;

endmodule

// File: doc/des_key_search.md
# des_key_search

Parametrised brute-force DES key-search engine. It is the multi-lane successor to the single-lane cracker top level. It accepts a known plaintext/ciphertext pair, a 56-bit key range and a direction mode. It sweeps the range with LANES parallel DES cores behind a one-stage result pipeline, then reports the lowest matching key with odd parity inserted. It sits between the board control logic (start/status) and the team's combinational DES core.

## Interface
Parameters:
- LANES, 4: parallel DES instances; power of two, 1..16.
- PIPE, 1: register stage between DES outputs and compare; 0 or 1. Default 1; everything below assumes 1, and PIPE=0 removes one cycle of latency.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; returns all state to IDLE.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- mode  in  1  1: encrypt plaintext and compare to ciphertext; 0: decrypt ciphertext and compare to plaintext.
- plaintext  in  64  known plaintext; latched on accepted start.
- ciphertext  in  64  known ciphertext; latched on accepted start.
- key_lo  in  56  first compressed key to test, inclusive; latched on accepted start.
- key_hi  in  56  last compressed key to test, inclusive; latched on accepted start.
- busy  out  1  high in SEARCH and DRAIN.
- done  out  1  sticky completion flag.
- found  out  1  valid when done; 1 means a match was found.
- key  out  64  matching key with parity bits, valid when found.
- count  out  56  base key of the batch currently being issued.

## Operation
- States: IDLE, SEARCH, DRAIN, DONE.
- IDLE to SEARCH: on start. Latch inputs, set count=key_lo, clear done and found.
- Accepted start with key_lo > key_hi: go straight to DONE next cycle with found=0.
- SEARCH, each cycle: lane i tests k = count+i. The lane is valid only if k <= key_hi, evaluated in 57-bit arithmetic so there is no wrap at 2^56-1. Then count += LANES.
- After issuing the batch that contains key_hi, go to DRAIN. count holds its last value.
- Lane key expansion: byte j of the 64-bit key is {k[7j+6:7j], ~^k[7j+6:7j]}, i.e. odd parity in bit 0. The DES core ignores the parity bits.
- Stage register: per-lane DES result, the valid mask, and the batch base.
- Compare stage: a lane hits if it is valid and its result equals the target. The target is ciphertext when mode=1 and plaintext when mode=0.
- Priority encode: the lowest-index hit wins. Batches are issued in ascending order, so the first hit is the lowest matching key in the range.
- Any hit in SEARCH or DRAIN: register found=1, done=1 and key = expanded(base+lane), then go to DONE. Batches still in flight are discarded.
- DRAIN with no hit once the last batch has been compared: done=1, found=0, go to DONE.
- DONE: done, found and key hold. A new start restarts the search exactly as from IDLE. start is ignored in SEARCH and DRAIN.
- reset in any state: next state IDLE. busy, done, found, key and count all become 0, and stage valids clear.

## Timing
- Start sampled in cycle 0. Batch b (b = 0..n-1, n = ceil((key_hi-key_lo+1)/LANES)) is issued in cycle 1+b.
- A hit in batch b gives found, done and key visible in cycle 3+b. busy falls in that same cycle.
- Exhaustive miss: done=1, found=0 visible in cycle n+2.
- Empty range (key_lo > key_hi): done visible in cycle 1.
- Throughput: LANES keys per cycle. No bubbles between batches.
- key_hi = 56'hFF_FFFF_FFFF_FFFF: the final partial batch masks lanes beyond the range and the search terminates. No wrap to 0.
- Reset asserted mid-search takes priority over a hit registering in the same cycle.

## Structure
- Shared package des_search_pkg: state enum, KEY56_W=56, BLOCK_W=64, and function expand_parity(56) returning 64.
- Sub-module key_parity_expand: combinational, one instance per lane.
- Per lane, instantiate the existing combinational DES core with encrypt = mode.
- Lanes are built with a generate loop. The FSM and counter live in this module.

## Test plan
- LANES=4, mode=1, pt=0123456789ABCDEF, ct=85E813540F0AB405, range [K-5, K+10] where K is the compressed form of 133457799BBCDFF1 -> found=1 and key=133457799BBCDFF1 in cycle 4.
- Same pair with mode=0, ct as the input -> identical key and cycle.
- Range [K+1, K+40] -> done=1, found=0 in cycle 12, and busy is high in cycles 1..11.
- key_lo=key_hi=56'hFF_FFFF_FFFF_FFFF with a non-matching pair -> one batch, done in cycle 3, no wrap (count never reads 0).
- key_lo > key_hi -> done=1, found=0 in cycle 1.
- reset pulsed in cycle 2 of a search -> all outputs 0 the next cycle; a fresh start gives the same result as a clean run.
- start pulsed during SEARCH -> ignored, and the result is unchanged.
